// File: rtl/dh_pkg.sv
// Shared constants, FSM state encoding and LFSR tap table for the DH key-agreement monitor.
package dh_pkg;

   localparam int unsigned DH_WIDTH = 16;
   localparam int unsigned DH_P = 65521;
   localparam int unsigned DH_G = 17;
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

   typedef enum logic [2:0] {
      LOAD,
      PUB_START,
      PUB_WAIT,
      SH_START,
      SH_WAIT,
      CHECK
   } state_t;

   // Maximal-length right-shift Galois taps for the widths in use
   function automatic logic [63:0] lfsr_taps(input int unsigned w);
      case (w)
         5: return 64'h14;
         8: return 64'hB8;
         16: return 64'(LFSR_TAPS_16);
         32: return 64'h8020_0003;
         default: return (64'd1 << (w - 1)) | 64'd1;
      endcase
   endfunction

endpackage

// File: rtl/modexp.sv
// Square-and-multiply modular exponentiation, one exponent bit per cycle, MSB first.
// done and result are presented during the last busy cycle; start while busy is ignored.
module modexp
   import dh_pkg::*;
#(
   parameter int unsigned WIDTH = DH_WIDTH,
   parameter int unsigned P = DH_P
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exp,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] PM = WIDTH'(P);
   localparam logic [2*WIDTH-1:0] PW = (2*WIDTH)'(P);

   function automatic logic [WIDTH-1:0] mulmod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [2*WIDTH-1:0] prod;
      prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
      return WIDTH'(prod % PW);
   endfunction

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] e;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] sq;
   logic [WIDTH-1:0] acc_next;
   logic             last;

   assign sq       = mulmod(acc, acc);
   assign acc_next = e[WIDTH-1] ? mulmod(sq, b) : sq;
   assign last     = busy && (cnt == LAST);
   assign done     = last;
   // Final value is forwarded in the last busy cycle so the caller can latch it without an extra cycle
   assign result   = last ? acc_next : result_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc      <= '0;
         b        <= '0;
         e        <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         result_q <= '0;
      end else if (!busy) begin
         if (start) begin
            acc  <= WIDTH'(1);
            b    <= base % PM;
            e    <= exp;
            cnt  <= '0;
            busy <= 1'b1;
         end
      end else begin
         acc <= acc_next;
         e   <= e << 1;
         cnt <= cnt + CW'(1);
         if (last) begin
            busy     <= 1'b0;
            result_q <= acc_next;
         end
      end
   end

endmodule

// File: rtl/monitor.sv
// Self-checking Diffie-Hellman monitor: two endpoints with LFSR private keys agree on a key each iteration.
// Iteration period is 2*WIDTH+4 cycles; outputs update only at the end of the CHECK cycle.
module monitor
   import dh_pkg::*;
#(
   parameter int unsigned WIDTH = DH_WIDTH,
   parameter int unsigned P = DH_P,
   parameter int unsigned G = DH_G,
   parameter logic [WIDTH-1:0] SEED_A = WIDTH'(16'hACE1),
   parameter logic [WIDTH-1:0] SEED_B = WIDTH'(16'h1D2C)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             synced,
   output logic [31:0]      sync_count,
   output logic [63:0]      iter_count,
   output logic [WIDTH-1:0] shared_key
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
   localparam logic [WIDTH-1:0] GW = WIDTH'(G);

   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
      return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   state_t state;
   logic [WIDTH-1:0] lfsr_a, lfsr_b;
   logic [WIDTH-1:0] priv_a, priv_b;
   logic [WIDTH-1:0] pub_a, pub_b;
   logic [WIDTH-1:0] k_a, k_b;
   logic             start_a, start_b;
   logic [WIDTH-1:0] base_a, base_b;
   logic             busy_a, busy_b, done_a, done_b;
   logic [WIDTH-1:0] res_a, res_b;
   logic             kick;

   // Both units run in lockstep: first pass raises G, second pass raises the peer's public value
   assign kick    = (state == PUB_START) || (state == SH_START);
   assign start_a = kick && !busy_a;
   assign start_b = kick && !busy_b;
   assign base_a  = (state == PUB_START) ? GW : pub_b;
   assign base_b  = (state == PUB_START) ? GW : pub_a;

   modexp #(.WIDTH(WIDTH), .P(P)) u_exp_a (
      .clk(clk), .rst(rst), .start(start_a), .base(base_a), .exp(priv_a),
      .busy(busy_a), .done(done_a), .result(res_a)
   );

   modexp #(.WIDTH(WIDTH), .P(P)) u_exp_b (
      .clk(clk), .rst(rst), .start(start_b), .base(base_b), .exp(priv_b),
      .busy(busy_b), .done(done_b), .result(res_b)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= LOAD;
         lfsr_a     <= SEED_A;
         lfsr_b     <= SEED_B;
         priv_a     <= WIDTH'(1);
         priv_b     <= WIDTH'(1);
         pub_a      <= '0;
         pub_b      <= '0;
         k_a        <= '0;
         k_b        <= '0;
         synced     <= 1'b0;
         sync_count <= '0;
         iter_count <= '0;
         shared_key <= '0;
      end else begin
         case (state)
            LOAD: begin
               priv_a <= (lfsr_a == '0) ? WIDTH'(1) : lfsr_a;
               priv_b <= (lfsr_b == '0) ? WIDTH'(1) : lfsr_b;
               state  <= PUB_START;
            end
            PUB_START: state <= PUB_WAIT;
            PUB_WAIT: begin
               if (done_a && done_b) begin
                  pub_a <= res_a;
                  pub_b <= res_b;
                  state <= SH_START;
               end
            end
            SH_START: state <= SH_WAIT;
            SH_WAIT: begin
               if (done_a && done_b) begin
                  k_a   <= res_a;
                  k_b   <= res_b;
                  state <= CHECK;
               end
            end
            CHECK: begin
               iter_count <= iter_count + 64'd1;
               synced     <= (k_a == k_b);
               if (k_a == k_b) sync_count <= sync_count + 32'd1;
               shared_key <= k_a;
               lfsr_a     <= lfsr_next(lfsr_a);
               lfsr_b     <= lfsr_next(lfsr_b);
               state      <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_monitor.sv
// Scoreboard bench: monitor with defaults and with P=23/G=5/W=5, plus a standalone modexp.
module tb_monitor;
   import dh_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int errors = 0;

   // default-parameter monitor
   logic        rst = 1'b1;
   logic        synced;
   logic [31:0] sync_count;
   logic [63:0] iter_count;
   logic [15:0] shared_key;

   monitor dut (
      .clk(clk), .rst(rst), .synced(synced), .sync_count(sync_count),
      .iter_count(iter_count), .shared_key(shared_key)
   );

   // small monitor, hand-checkable numbers
   logic        rst_s = 1'b1;
   logic        synced_s;
   logic [31:0] sync_count_s;
   logic [63:0] iter_count_s;
   logic [4:0]  shared_key_s;

   monitor #(.WIDTH(5), .P(23), .G(5), .SEED_A(5'd6), .SEED_B(5'd15)) dut_s (
      .clk(clk), .rst(rst_s), .synced(synced_s), .sync_count(sync_count_s),
      .iter_count(iter_count_s), .shared_key(shared_key_s)
   );

   // standalone modexp
   logic       rst_m = 1'b1;
   logic       start_m = 1'b0;
   logic [4:0] base_m = '0;
   logic [4:0] exp_m = '0;
   logic       busy_m, done_m;
   logic [4:0] result_m;

   modexp #(.WIDTH(5), .P(23)) u_mx (
      .clk(clk), .rst(rst_m), .start(start_m), .base(base_m), .exp(exp_m),
      .busy(busy_m), .done(done_m), .result(result_m)
   );

   typedef struct {
      logic        synced;
      logic [31:0] sc;
      logic [63:0] ic;
      logic [15:0] key;
   } exp_t;

   typedef struct {
      logic [4:0] res;
      longint     done_cyc;
   } mx_t;

   exp_t exp_q[$];
   mx_t  mx_q[$];

   logic [15:0] m_la, m_lb;
   logic [31:0] m_sc;
   logic [63:0] m_ic;
   logic [15:0] kb_forced;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic longint unsigned powmod(input longint unsigned b0, input longint unsigned e0,
                                              input longint unsigned p);
      longint unsigned r, b, e;
      r = 1;
      b = b0 % p;
      e = e0;
      while (e != 0) begin
         if (e[0]) r = (r * b) % p;
         b = (b * b) % p;
         e = e >> 1;
      end
      return r;
   endfunction

   function automatic logic [15:0] lfsr16(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   task automatic model_reset();
      m_la = 16'hACE1;
      m_lb = 16'h1D2C;
      m_sc = '0;
      m_ic = '0;
   endtask

   task automatic model_iter(input bit fault, output exp_t e, output logic [15:0] kb);
      longint unsigned pa, pb, pua, pub, ka;
      pa  = (m_la == 16'd0) ? 1 : longint'(m_la);
      pb  = (m_lb == 16'd0) ? 1 : longint'(m_lb);
      pua = powmod(17, pa, 65521);
      pub = powmod(17, pb, 65521);
      ka  = powmod(pub, pa, 65521);
      kb  = 16'(powmod(pua, pb, 65521));
      m_ic = m_ic + 64'd1;
      if (!fault) m_sc = m_sc + 32'd1;
      e.synced = !fault;
      e.sc     = m_sc;
      e.ic     = m_ic;
      e.key    = 16'(ka);
      m_la = lfsr16(m_la);
      m_lb = lfsr16(m_lb);
   endtask

   task automatic push_iters(input int n);
      exp_t e;
      logic [15:0] kb;
      for (int i = 0; i < n; i++) begin
         model_iter(1'b0, e, kb);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_iter(input logic [63:0] n, input int budget);
      int k;
      k = 0;
      while (iter_count != n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("wait_iter", iter_count, n);
   endtask

   task automatic mx_start(input logic [4:0] b, input logic [4:0] e, input bit expect_it,
                           input logic [4:0] res);
      mx_t m;
      @(negedge clk);
      start_m = 1'b1;
      base_m  = b;
      exp_m   = e;
      if (expect_it) begin
         m.res      = res;
         m.done_cyc = cyc + 5;
         mx_q.push_back(m);
      end
      @(negedge clk);
      start_m = 1'b0;
   endtask

   // scoreboard for the default monitor: one expectation per completed iteration
   initial begin
      logic [63:0] prev;
      exp_t e;
      prev = '0;
      forever begin
         @(negedge clk);
         if (rst && iter_count != prev && iter_count != 64'd0) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL sb_unexpected: actual iter %0d required no iteration", iter_count);
            end else begin
               e = exp_q.pop_front();
               check("sb_iter_count", iter_count, e.ic);
               check("sb_sync_count", 64'(sync_count), 64'(e.sc));
               check("sb_synced", 64'(synced), 64'(e.synced));
               check("sb_shared_key", 64'(shared_key), 64'(e.key));
            end
         end
         prev = iter_count;
      end
   end

   // scoreboard for the standalone modexp
   initial begin
      mx_t m;
      forever begin
         @(negedge clk);
         if (rst_m && done_m) begin
            if (mx_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL mx_unexpected_done: actual result %0d at cycle %0d required none", result_m, cyc);
            end else begin
               m = mx_q.pop_front();
               check("mx_result", 64'(result_m), 64'(m.res));
               check("mx_done_cycle", 64'(cyc), 64'(m.done_cyc));
            end
         end
      end
   end

   initial begin
      exp_t e;
      logic [15:0] kb;
      #2;
      rst = 1'b0;
      rst_s = 1'b0;
      rst_m = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_synced", 64'(synced), 0);
      check("rst_sync_count", 64'(sync_count), 0);
      check("rst_iter_count", iter_count, 0);
      check("rst_shared_key", 64'(shared_key), 0);

      // small config: pubA=8, pubB=19, kA=kB=2, done at cycle 14
      @(negedge clk);
      rst_s = 1'b1;
      repeat (13) @(posedge clk);
      #1;
      check("small_iter_before", iter_count_s, 0);
      @(posedge clk);
      #1;
      check("small_iter_count", iter_count_s, 1);
      check("small_sync_count", 64'(sync_count_s), 1);
      check("small_synced", 64'(synced_s), 1);
      check("small_shared_key", 64'(shared_key_s), 2);
      check("small_pub_a", 64'(dut_s.pub_a), 8);
      check("small_pub_b", 64'(dut_s.pub_b), 19);
      check("small_k_b", 64'(dut_s.k_b), 2);

      // standalone modexp: 5^6=8, 7^0=1, 30^6 == 7^6 = 4 (mod 23)
      @(negedge clk);
      rst_m = 1'b1;
      mx_start(5'd5, 5'd6, 1'b1, 5'd8);
      repeat (6) @(negedge clk);
      mx_start(5'd7, 5'd0, 1'b1, 5'd1);
      repeat (6) @(negedge clk);
      mx_start(5'd30, 5'd6, 1'b1, 5'd4);
      repeat (6) @(negedge clk);
      mx_start(5'd5, 5'd6, 1'b1, 5'd8);
      mx_start(5'd3, 5'd1, 1'b0, 5'd0);
      repeat (10) @(negedge clk);
      check("mx_queue_drained", 64'(mx_q.size()), 0);

      // default monitor: two iterations, then reset in SH_WAIT of the third
      model_reset();
      push_iters(2);
      @(negedge clk);
      rst = 1'b1;
      wait_iter(64'd2, 120);
      repeat (24) @(negedge clk);
      check("mid_state_sh_wait", 64'(dut.state), 64'(SH_WAIT));
      rst = 1'b0;
      #1;
      check("mid_rst_synced", 64'(synced), 0);
      check("mid_rst_sync_count", 64'(sync_count), 0);
      check("mid_rst_iter_count", iter_count, 0);
      check("mid_rst_shared_key", 64'(shared_key), 0);

      // restart from the seeds: same keys as the first run
      model_reset();
      push_iters(100);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_iter(64'd100, 100 * 36 + 60);

      // corrupt kB for one iteration
      model_iter(1'b1, e, kb);
      kb_forced = kb ^ 16'h0001;
      force dut.k_b = kb_forced;
      exp_q.push_back(e);
      wait_iter(64'd101, 80);
      release dut.k_b;
      push_iters(1);
      wait_iter(64'd102, 80);
      repeat (3) @(negedge clk);
      check("sb_queue_drained", 64'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/monitor.md
Name: monitor

Overview:
- Self-checking Diffie-Hellman key-agreement monitor.
- Holds two endpoints, A and B, with private keys taken from internal LFSRs. Each iteration it computes the public values, then both shared keys, and compares them.
- Reports agreement on `synced` and keeps iteration and agreement counters.
- Top-level self-test block: clock and reset in, status out.

Parameters:
- WIDTH, 16, bit width of the modulus, keys and exponents.
- P, 65521, prime modulus; must satisfy 2 <= P < 2**WIDTH.
- G, 17, generator; must satisfy 1 < G < P.
- SEED_A, 16'hACE1, first private key for A; nonzero.
- SEED_B, 16'h1D2C, first private key for B; nonzero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- synced  out  1  high when the most recently completed iteration produced equal keys.
- sync_count  out  32  number of iterations whose keys matched.
- iter_count  out  64  number of completed iterations.
- shared_key  out  WIDTH  key computed by A in the most recently completed iteration.

Behaviour:
- Reset (rst=0), asynchronous:
  - synced=0, sync_count=0, iter_count=0, shared_key=0.
  - lfsr_a=SEED_A, lfsr_b=SEED_B.
  - FSM goes to LOAD; both modexp units go idle.
- FSM, one state per cycle except the WAIT states:
  - LOAD: latch priv_a=lfsr_a and priv_b=lfsr_b; a zero key is replaced by 1.
  - PUB_START: pulse start on both units: unit A computes G^priv_a mod P, unit B computes G^priv_b mod P.
  - PUB_WAIT: hold until both done pulses (simultaneous by construction); latch pubA and pubB.
  - SH_START: start unit A on pubB^priv_a and unit B on pubA^priv_b.
  - SH_WAIT: wait for both done pulses; latch kA and kB.
  - CHECK:
    - iter_count += 1.
    - synced <= (kA==kB); if equal, sync_count += 1.
    - shared_key <= kA.
    - Both LFSRs advance one step.
    - Go to LOAD.
- Iteration period: exactly 2*WIDTH+4 cycles. Outputs change only in the CHECK cycle.
- LFSR: Galois, WIDTH bits, right shift; taps 16'hB400 when WIDTH=16. The state never reaches zero from a nonzero seed.
- Counters wrap modulo 2**32 and 2**64.
- Reset mid-iteration aborts the iteration; no partial counter update.
- Sub-module modexp(WIDTH,P):
  - Ports: clk, rst, start, base[WIDTH], exp[WIDTH], busy, done, result[WIDTH].
  - On start while idle: acc=1, b=base mod P, e=exp; busy=1.
  - Each busy cycle handles one exponent bit, MSB first:
    - acc = acc*acc mod P;
    - if the bit is 1: acc = acc*b mod P.
    - Products are 2*WIDTH bits wide, then reduced mod P.
  - After exactly WIDTH busy cycles: done pulses 1 cycle, result=acc, busy=0.
  - start while busy is ignored.
  - exp=0 gives result 1.
- With P prime and exponent arithmetic exact, kA==kB always holds. synced therefore rises at the first CHECK and stays high. A mismatch indicates a datapath fault.

Decomposition:
- Package dh_pkg:
  - default WIDTH, P, G and LFSR tap constants;
  - FSM state enum {LOAD, PUB_START, PUB_WAIT, SH_START, SH_WAIT, CHECK}.
- One sub-module, modexp (square-and-multiply, with the mulmod function inside it), instantiated twice in monitor.

Test Plan:
- Reset, release, first iteration with P=23, G=5, SEED_A=6, SEED_B=15, WIDTH=5:
  - expect pubA=8, pubB=19, kA=kB=2;
  - at cycle 2*5+4 after release: shared_key=2, synced=1, iter_count=1, sync_count=1.
- Defaults, run 100 iterations: iter_count=100, sync_count=100, synced stays 1, no X on any output.
- Standalone modexp with P=23:
  - 5^6 -> 8 with done exactly 5 cycles after start;
  - 7^0 -> 1;
  - base 30 -> treated as 7.
- Assert rst low in the middle of SH_WAIT of iteration 3:
  - outputs clear to 0 immediately;
  - the next iteration restarts from SEED_A/SEED_B and gives the same shared_key as the first run.
- Force kB bit0 inverted via bench force for one iteration: synced=0, sync_count does not increment, iter_count increments; releasing the force restores synced=1.
- Pulse start while modexp is busy: it is ignored; result and done timing are unchanged.
